// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 4-digit 7-segment display bus.
// The display driver and the scan decoder both import this package, so the
// glyph encoding exists in exactly one place.
//   NUM_DIGITS    : digits on the bus (one select line each)
//   SEG_A..SEG_DP : bit positions inside the 8-bit segment vector
//   GLYPH_TBL     : 7-bit pattern (g..a) for hex nibbles 0..F, index = nibble
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Element [0] is the rightmost entry of the concatenation.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scanned display bus plus the decoded-frame outputs of the monitor.
//   segmentos   : segment lines, [0]=a .. [6]=g, [7]=dp (raw polarity)
//   sel_seg     : digit select lines (raw polarity), [0]=least-significant digit
//   value       : last good frame, digit k in [4k+3:4k]
//   dp          : decimal points of the last good frame
//   frame_valid : one-cycle pulse when value/dp update
//   frame_err   : one-cycle pulse when a frame completes with an undecodable digit
//   link_lost   : level, high until a good frame and again after a timeout
// master drives the bus (display side / testbench); slave is the decoder.
interface seg_scan_decoder_if;
  import seg_pkg::*;

  logic [7:0]              segmentos;
  logic [NUM_DIGITS-1:0]   sel_seg;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    frame_valid;
  logic                    frame_err;
  logic                    link_lost;

  modport master (
    output segmentos, sel_seg,
    input  value, dp, frame_valid, frame_err, link_lost
  );

  modport slave (
    input  segmentos, sel_seg,
    output value, dp, frame_valid, frame_err, link_lost
  );

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the display glyph table.
//   pat : 7-bit segment pattern (g..a), already active-high
//   nib : decoded hex nibble, 0 when the pattern is not a glyph
//   vld : pattern matches one of the 16 glyphs (blank is not a glyph)
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nib,
  output logic       vld
);

  always_comb begin
    nib = '0;
    vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat == GLYPH_TBL[i]) begin
        nib = 4'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 7-segment display bus.
// Registers the bus once (polarity normalised), accepts a digit after it has
// been held unchanged for STABLE_CYC further cycles, decodes it into its slot
// and publishes a 16-bit value once all four digits of a frame were seen.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : seg_scan_decoder_if.slave (display bus in, frame outputs)
// Parameters: STABLE_CYC (>=1) dwell cycles, TIMEOUT_CYC capture-free cycles
// before link loss, SEG_/SEL_ACTIVE_LOW input polarity.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYC     = 4,
  parameter int TIMEOUT_CYC    = 4096,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam int ND = NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]          seg_q, seg_d, seg_prev_q, seg_prev_d;
  logic [ND-1:0]       sel_q, sel_d, sel_prev_q, sel_prev_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [ND-1:0]       seen_q, seen_d, bad_q, bad_d;
  logic [ND-1:0]       dpslot_q, dpslot_d, dp_q, dp_d;
  logic [ND-1:0][3:0]  slot_q, slot_d, value_q, value_d;
  logic                fv_q, fv_d, fe_q, fe_d, lost_q, lost_d;

  logic [3:0]          dec_nib;
  logic                dec_ok;
  logic                sel_onehot, stay, capture;

  seg7_to_hex u_dec (
    .pat (seg_q[SEG_G:SEG_A]),
    .nib (dec_nib),
    .vld (dec_ok)
  );

  assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
  // Same legal pair as last cycle: the dwell continues.
  assign stay    = sel_onehot && (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
  // Fires only on the step into saturation, so a long dwell captures once.
  assign capture = stay && (cnt_q == CW'(STABLE_CYC - 1));

  always_comb begin
    seg_d      = bus.segmentos ^ {8{SEG_ACTIVE_LOW}};
    sel_d      = bus.sel_seg ^ {ND{SEL_ACTIVE_LOW}};
    seg_prev_d = seg_q;
    sel_prev_d = sel_q;

    cnt_d = '0;
    if (stay) cnt_d = (cnt_q == CW'(STABLE_CYC)) ? cnt_q : cnt_q + 1'b1;

    seen_d   = seen_q;
    bad_d    = bad_q;
    slot_d   = slot_q;
    dpslot_d = dpslot_q;
    value_d  = value_q;
    dp_d     = dp_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;
    lost_d   = lost_q;
    tmo_d    = tmo_q;

    // Frame completion looks at last cycle's seen; a capture below in the
    // same cycle starts the next frame.
    if (&seen_q) begin
      if (bad_q == '0) begin
        value_d = slot_q;
        dp_d    = dpslot_q;
        fv_d    = 1'b1;
        lost_d  = 1'b0;
      end else begin
        fe_d = 1'b1;
      end
      seen_d = '0;
      bad_d  = '0;
    end

    if (capture) begin
      tmo_d = '0;
      for (int k = 0; k < ND; k++) begin
        if (sel_q[k]) begin
          slot_d[k]   = dec_nib;
          dpslot_d[k] = seg_q[SEG_DP];
          seen_d[k]   = 1'b1;
          bad_d[k]    = ~dec_ok;
        end
      end
    end else if (tmo_q != TW'(TIMEOUT_CYC)) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        lost_d = 1'b1;
        seen_d = '0;
        bad_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q      <= '0;
      sel_q      <= '0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      seen_q     <= '0;
      bad_q      <= '0;
      slot_q     <= '0;
      dpslot_q   <= '0;
      value_q    <= '0;
      dp_q       <= '0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      lost_q     <= 1'b1;
    end else begin
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      seg_prev_q <= seg_prev_d;
      sel_prev_q <= sel_prev_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      seen_q     <= seen_d;
      bad_q      <= bad_d;
      slot_q     <= slot_d;
      dpslot_q   <= dpslot_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.dp          = dp_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;
  assign bus.link_lost   = lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios followed by random scanning,
// every cycle compared with a run-length based reference model.
module tb_seg_scan_decoder;

  localparam int SC = 4;
  localparam int TC = 150;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(
    .STABLE_CYC     (SC),
    .TIMEOUT_CYC    (TC),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_cmp = 0;
  int n_bad = 0;
  int n_fv  = 0;
  int n_fe  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (logical polarity) ----------------
  int         m_slot [4];
  bit         m_dps  [4];
  bit         m_seen [4];
  bit         m_bad  [4];
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  bit         m_lost, m_fv, m_fe;
  int         m_idle, m_run;
  logic [7:0] m_lseg;
  logic [3:0] m_lsel;

  function automatic int decode(logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  task automatic model_clear_frame();
    for (int k = 0; k < 4; k++) begin
      m_seen[k] = 0;
      m_bad[k]  = 0;
    end
  endtask

  // One clock edge. A capture at this edge belongs to a pair that has been
  // on the bus for SC+1 consecutive cycles ending last cycle.
  task automatic model_step(logic [7:0] seg, logic [3:0] sel, bit rst);
    bit cap, all_seen, any_bad;
    logic [7:0] cseg;
    logic [3:0] csel;
    int g;
    if (rst) begin
      m_value = 0; m_dp = 0; m_lost = 1; m_fv = 0; m_fe = 0;
      m_idle = 0; m_run = 0; m_lseg = 0; m_lsel = 0;
      for (int k = 0; k < 4; k++) begin
        m_slot[k] = 0; m_dps[k] = 0;
      end
      model_clear_frame();
      return;
    end
    cap  = (m_run == SC + 1);
    cseg = m_lseg;
    csel = m_lsel;
    m_fv = 0;
    m_fe = 0;
    all_seen = 1;
    any_bad  = 0;
    for (int k = 0; k < 4; k++) begin
      all_seen &= m_seen[k];
      any_bad  |= m_bad[k];
    end
    if (all_seen) begin
      if (!any_bad) begin
        for (int k = 0; k < 4; k++) begin
          m_value[4*k +: 4] = 4'(m_slot[k]);
          m_dp[k] = m_dps[k];
        end
        m_fv   = 1;
        m_lost = 0;
      end else begin
        m_fe = 1;
      end
      model_clear_frame();
    end
    if (cap) begin
      for (int k = 0; k < 4; k++) begin
        if (csel[k]) begin
          g = decode(cseg[6:0]);
          m_slot[k] = (g < 0) ? 0 : g;
          m_dps[k]  = cseg[7];
          m_seen[k] = 1;
          m_bad[k]  = (g < 0);
        end
      end
      m_idle = 0;
    end else if (m_idle < TC) begin
      m_idle++;
      if (m_idle == TC) begin
        m_lost = 1;
        model_clear_frame();
      end
    end
    if ($countones(sel) == 1 && seg == m_lseg && sel == m_lsel) begin
      if (m_run < SC + 2) m_run++;
    end else begin
      m_run = ($countones(sel) == 1) ? 1 : 0;
    end
    m_lseg = seg;
    m_lsel = sel;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(logic [7:0] seg, logic [3:0] sel, bit rst = 0);
    @(negedge clk);
    bus.segmentos = ~seg;  // bus is active-low on segments
    bus.sel_seg   = sel;
    rst_n         = !rst;
    @(posedge clk);
    model_step(seg, sel, rst);
    #1;
    chk("value",       bus.value,       m_value);
    chk("dp",          bus.dp,          m_dp);
    chk("frame_valid", bus.frame_valid, m_fv);
    chk("frame_err",   bus.frame_err,   m_fe);
    chk("link_lost",   bus.link_lost,   m_lost);
    if (bus.frame_valid) n_fv++;
    if (bus.frame_err) n_fe++;
  endtask

  task automatic show(int k, logic [6:0] g, bit dpb, int n);
    repeat (n) cyc({dpb, g}, 4'(1 << k));
  endtask

  task automatic scan(logic [15:0] v, logic [3:0] dpm, int dwell);
    logic [3:0] nib;
    for (int k = 0; k < 4; k++) begin
      nib = v[4*k +: 4];
      show(k, glyph[nib], dpm[k], dwell);
    end
  endtask

  logic [3:0] bad_sel [8] = '{4'h0, 4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hF};
  int r, k0, fv0, fe0;
  logic [6:0] gr;

  initial begin
    bus.segmentos = 8'hFF;
    bus.sel_seg   = 4'h0;
    cyc(8'h00, 4'h0, 1);
    cyc(8'h00, 4'h0, 1);
    chk("rst_value", bus.value, 16'h0);
    chk("rst_lost",  bus.link_lost, 1);

    // good scan
    fv0 = n_fv;
    scan(16'h1234, 4'h0, 8);
    cyc(8'h00, 4'h0);
    chk("good_value", bus.value, 16'h1234);
    chk("good_lost",  bus.link_lost, 0);
    chk("good_pulses", n_fv - fv0, 1);

    // glitch rejection: 8 shown too briefly, 9 captured
    show(0, 7'h7F, 0, 3);
    show(0, 7'h6F, 0, 8);
    show(1, glyph[3], 0, 8);
    show(2, glyph[2], 0, 8);
    show(3, glyph[1], 0, 8);
    cyc(8'h00, 4'h0);
    chk("glitch_value", bus.value, 16'h1239);
    // long dwell captures once
    fv0 = n_fv;
    show(0, 7'h7F, 0, 20);
    show(1, glyph[3], 0, 8);
    show(2, glyph[2], 0, 8);
    show(3, glyph[1], 0, 8);
    cyc(8'h00, 4'h0);
    chk("dwell_value", bus.value, 16'h1238);
    chk("dwell_pulses", n_fv - fv0, 1);

    // bad glyph on digit 2
    fv0 = n_fv; fe0 = n_fe;
    show(0, glyph[4], 0, 8);
    show(1, glyph[3], 0, 8);
    show(2, 7'h49, 0, 8);
    show(3, glyph[1], 0, 8);
    cyc(8'h00, 4'h0);
    chk("bad_value", bus.value, 16'h1238);
    chk("bad_fe", n_fe - fe0, 1);
    chk("bad_fv", n_fv - fv0, 0);

    // illegal selects
    repeat (50) cyc({1'b0, glyph[5]}, 4'b0101);
    repeat (50) cyc({1'b0, glyph[5]}, 4'b0000);

    // timeout after a partial frame
    show(0, glyph[7], 0, 8);
    show(1, glyph[7], 0, 8);
    repeat (TC + 10) cyc(8'h00, 4'h0);
    chk("tmo_lost", bus.link_lost, 1);
    scan(16'hABCD, 4'b0010, 8);
    cyc(8'h00, 4'h0);
    chk("abcd_value", bus.value, 16'hABCD);
    chk("abcd_dp",    bus.dp, 4'b0010);

    // reset mid-frame
    show(0, glyph[8], 0, 8);
    show(1, glyph[7], 0, 8);
    show(2, glyph[6], 0, 8);
    cyc(8'h00, 4'h0, 1);
    chk("midrst_value", bus.value, 16'h0);
    show(3, glyph[5], 0, 8);
    chk("midrst_nofr", bus.value, 16'h0);
    scan(16'h5678, 4'h0, 8);
    cyc(8'h00, 4'h0);
    chk("midrst_frame", bus.value, 16'h5678);

    // random scanning
    repeat (300) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cyc(8'h00, 4'h0, 1);
      end else if (r < 6) begin
        repeat ($urandom_range(TC - 5, TC + 5)) cyc(8'($urandom), 4'h0);
      end else if (r < 12) begin
        repeat ($urandom_range(1, 12)) cyc(8'($urandom), bad_sel[$urandom_range(0, 7)]);
      end else begin
        k0 = $urandom_range(0, 3);
        gr = (r < 22) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
        show(k0, gr, 1'($urandom), $urandom_range(1, 10));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
